// File: rtl/multiply_if.sv
`default_nettype none
// ============================================================================
// Module      : multiply_if
// Description : Operand/product bundle for the 4x4 unsigned multiplier.
//               master = operand source / product sink, slave = multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiply_if;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] out;
    logic       out_valid;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/multiply.sv
`default_nettype none
// ============================================================================
// Module      : multiply
// Description : 4x4 unsigned array multiplier with a registered 8-bit product.
//               Four AND-gated partial products are summed by a two-level
//               adder tree. Latency is 1 cycle; defining MULTIPLY_INREG_EN
//               adds an input register stage for a latency of 2 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module multiply (
    input  wire logic  clk,
    input  wire logic  rst_n,
    multiply_if.slave  bus
);

    logic       array_valid;
    logic [3:0] array_a;
    logic [3:0] array_b;
    logic [7:0] pp [4];
    logic [7:0] sum_lo;
    logic [7:0] sum_hi;
    logic [7:0] product;

`ifdef MULTIPLY_INREG_EN
    logic       stage_valid;
    logic [3:0] stage_a;
    logic [3:0] stage_b;

    // Input capture stage; reset drops any pair still in flight here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_a     <= 4'd0;
            stage_b     <= 4'd0;
        end else begin
            stage_valid <= bus.in_valid;
            stage_a     <= bus.a;
            stage_b     <= bus.b;
        end
    end

    assign array_valid = stage_valid;
    assign array_a     = stage_a;
    assign array_b     = stage_b;
`else
    assign array_valid = bus.in_valid;
    assign array_a     = bus.a;
    assign array_b     = bus.b;
`endif

    // Partial product i is the multiplicand gated by multiplier bit i,
    // placed at weight 2^i inside the 8-bit product field.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_pp
            assign pp[i] = {4'b0000, array_a & {4{array_b[i]}}} << i;
        end
    endgenerate

    // Two-level carry-propagating tree; 225 max so 8 bits never overflow.
    assign sum_lo  = pp[0] + pp[1];
    assign sum_hi  = pp[2] + pp[3];
    assign product = sum_lo + sum_hi;

    // Output register: load on a valid pair, otherwise hold the last product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= 8'd0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= array_valid;
            if (array_valid) begin
                bus.out <= product;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiply.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiply
// Description : Self-checking bench for multiply. The reference model keeps
//               the last LAT sampled pairs as a delay line and forms products
//               with plain arithmetic; out holds the last delivered product.
//               Build with MULTIPLY_INREG_EN to check the 2-cycle variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiply;

`ifdef MULTIPLY_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    multiply_if bus ();

    multiply dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: history of sampled pairs, newest at index 0.
    logic       hist_v [LAT];
    int         hist_p [LAT];
    int         exp_out;
    logic       exp_valid;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LAT; i++) begin
            hist_v[i] = 1'b0;
            hist_p[i] = 0;
        end
        exp_out   = 0;
        exp_valid = 1'b0;
    endtask

    // Apply one pair, clock it, then compare after the edge.
    task automatic step(input string tag, input logic v, input int av, input int bv);
        bus.in_valid = v;
        bus.a        = 4'(av);
        bus.b        = 4'(bv);
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_p[i] = hist_p[i-1];
        end
        hist_v[0] = v;
        hist_p[0] = av * bv;
        exp_valid = hist_v[LAT-1];
        if (exp_valid) exp_out = hist_p[LAT-1];
        chk({tag, ".out"}, bus.out, 8'(exp_out));
        chk({tag, ".valid"}, {7'd0, bus.out_valid}, {7'd0, exp_valid});
    endtask

    // Hold phase: operands wiggle mid-cycle while in_valid is low.
    task automatic idle_toggle(input string tag);
        bus.in_valid = 1'b0;
        bus.a = 4'($urandom_range(0, 15));
        #2 bus.b = 4'($urandom_range(0, 15));
        #2 bus.a = 4'($urandom_range(0, 15));
        step(tag, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endtask

    int zi_a [11] = '{0, 0, 1, 1, 1, 1, 15, 10, 9, 10, 2};
    int zi_b [11] = '{0, 1, 1, 2, 3, 10, 15, 10, 8, 2, 2};

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 4'd0;
        bus.b        = 4'd0;
        model_clear();
        #1;
        chk("reset.out", bus.out, 8'd0);
        chk("reset.valid", {7'd0, bus.out_valid}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero, identity, maximum and mid-range pairs, isolated then flushed.
        for (int k = 0; k < 11; k++) begin
            step("vec", 1'b1, zi_a[k], zi_b[k]);
            for (int j = 0; j < LAT; j++) step("vec_flush", 1'b0, 0, 0);
        end

        // Same pairs back to back.
        for (int k = 0; k < 11; k++) step("vec_b2b", 1'b1, zi_a[k], zi_b[k]);

        // Exhaustive back-to-back sweep of all 256 pairs.
        for (int i = 0; i < 256; i++) step("sweep", 1'b1, i / 16, i % 16);
        for (int j = 0; j < LAT; j++) step("sweep_flush", 1'b0, 0, 0);

        // Hold: 9*8 then idle with toggling operands.
        step("hold_load", 1'b1, 9, 8);
        for (int j = 0; j < LAT + 3; j++) idle_toggle("hold");
        chk("hold_final", bus.out, 8'd72);

        // Randomized traffic with sparse valids.
        for (int j = 0; j < 300; j++)
            step("rand", 1'($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

        // Mid-stream reset with 15*15 streaming: asynchronous clear, no stale 225.
        step("pre_rst", 1'b1, 15, 15);
        bus.in_valid = 1'b1;
        bus.a = 4'd15;
        bus.b = 4'd15;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_async.out", bus.out, 8'd0);
        chk("rst_async.valid", {7'd0, bus.out_valid}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.out", bus.out, 8'd0);
        chk("rst_hold.valid", {7'd0, bus.out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < LAT + 2; j++) step("post_rst", 1'b0, 15, 15);

        // A pair accepted one cycle before reset must never surface.
        step("inflight", 1'b1, 15, 15);
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        chk("inflight_rst.valid", {7'd0, bus.out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < LAT + 1; j++) step("inflight_post", 1'b0, 0, 0);

        // First pair after release follows normal latency.
        step("first_after", 1'b1, 10, 10);
        for (int j = 0; j < LAT; j++) step("first_flush", 1'b0, 3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiply.md
MULTIPLY -- requirements
Module: multiply

Interface
REQ-001 clk  input  1  Sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  Reset, asynchronous assert, active-low; deassertion synchronized to clk by the integrating block.
REQ-003 in_valid  input  1  Qualifies a/b as a new operand pair this cycle.
REQ-004 a  input  4  Multiplicand, unsigned 0..15.
REQ-005 b  input  4  Multiplier, unsigned 0..15.
REQ-006 out  output  8  Registered unsigned product a*b, 0..225.
REQ-007 out_valid  output  1  High for one cycle per accepted pair; out holds that pair's product.

Function
REQ-008 Product SHALL be exact unsigned a*b in 8 bits; no overflow possible (max 15*15=225), no truncation, no sign handling.
REQ-009 Product SHALL be formed as an explicit array: 4 partial products (a AND b[i]) shifted by i, summed by a carry-propagating adder tree; no use of the `*` operator.
REQ-010 Default latency SHALL be 1 cycle: pair sampled at edge N appears on out, with out_valid=1, after edge N.
REQ-011 in_valid=1 SHALL be accepted every cycle; no back-pressure, no stall, full throughput.
REQ-012 in_valid=0 SHALL leave out holding its last value and drive out_valid=0 in the corresponding output cycle.
REQ-013 Operand 0 on either input SHALL yield out=0; operand 1 SHALL yield the other operand zero-extended.
REQ-014 Changes to a/b between edges SHALL have no effect on out; out is glitch-free (register-driven).

Reset
REQ-015 rst_n=0 SHALL immediately force out=8'd0, out_valid=0, and clear all internal pipeline registers, including any in-flight valid.
REQ-016 A pair accepted before a mid-operation reset SHALL be discarded; no out_valid for it after release.
REQ-017 First accepted pair after rst_n rises SHALL follow the normal latency.

Configuration
REQ-018 Macro MULTIPLY_INREG_EN: when defined, a/b/in_valid SHALL be registered before the partial-product array, making latency 2 cycles (both out and out_valid delayed identically); when undefined, latency is 1 cycle per REQ-010.
REQ-019 The input register stage under MULTIPLY_INREG_EN SHALL reset to zero and follow REQ-015/REQ-016.

Verification
REQ-020 Reset: rst_n=0 mid-stream with in_valid=1, a=15, b=15 -> out=0, out_valid=0 at once; no stale 225 after release.
REQ-021 Zero/identity: (0,0)->0, (0,1)->0, (1,1)->1, (1,2)->2, (1,3)->3, (1,10)->10, each after configured latency with out_valid=1.
REQ-022 Maximum and mid-range: (15,15)->225, (10,10)->100, (9,8)->72, (10,2)->20, (2,2)->4.
REQ-023 Back-to-back in_valid=1 for all 256 pairs -> 256 consecutive out_valid pulses, each out equal to reference a*b, in order.
REQ-024 Hold: in_valid=1 (9,8) then in_valid=0 with a/b toggling -> out stays 72, out_valid=0.
REQ-025 Run REQ-020..REQ-024 with and without MULTIPLY_INREG_EN; latency 1 vs 2 checked cycle-exactly.
